button_bank: RTL and testbench

//  N-channel button front end for the game controller. Each channel

---
 rtl/button_bank.sv | 131 +++++++++++++
 tb/tb_button_bank.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// N-channel key front end: 2-flop sync, counter debounce, and a per-channel
// request FSM with ack handshake and optional delayed auto-repeat.
module button_bank #(
  parameter int unsigned          N_BUTTONS         = 4,
  parameter int unsigned          DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned          REPEAT_DELAY      = 8500000,
  parameter int unsigned          REPEAT_RATE       = 2500000,
  parameter logic [N_BUTTONS-1:0] REPEAT_EN         = N_BUTTONS'(4'b0011),
  parameter bit                   BUTTON_ACTIVE_LOW = 1'b0,
  parameter int unsigned          LED_CHANNEL       = 0
) (
  input  logic                 clk,
  input  logic                 iReset,
  input  logic [N_BUTTONS-1:0] iButton,
  input  logic [N_BUTTONS-1:0] iOffSignal,
  output logic [N_BUTTONS-1:0] oSignal,
  output logic [N_BUTTONS-1:0] oDebounced,
  output logic [4:0]           oLEDs
);

  localparam int unsigned DCW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REPEAT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW         = $clog2(REPEAT_MAX + 1);

  // One-hot codes double as the LED pattern; bit 3 is never lit.
  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_PENDING = 5'b00010,
    S_LATCHED = 5'b00100,
    S_HELD    = 5'b10000
  } state_e;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    logic           raw;
    logic           sync1_q, sync2_q;
    logic           deb_q, deb_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [TW-1:0]  limit;
    logic           first_q, first_d;

    assign raw = iButton[g] ^ BUTTON_ACTIVE_LOW;

    always_ff @(posedge clk) begin
      if (iReset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
        state_q <= S_IDLE;
        timer_q <= '0;
        first_q <= 1'b0;
      end else begin
        sync1_q <= raw;
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
        state_q <= state_d;
        timer_q <= timer_d;
        first_q <= first_d;
      end
    end

    always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (sync2_q == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // first is armed on the IDLE->PENDING edge so that only a fresh press
    // gets the long delay; repeat-driven PENDING->HELD keeps it cleared.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      first_d = first_q;
      limit   = first_q ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_RATE - 1);
      unique case (state_q)
        S_IDLE: begin
          if (deb_q) begin
            state_d = S_PENDING;
            first_d = 1'b1;
          end
        end
        S_PENDING: begin
          if (iOffSignal[g]) begin
            if (deb_q) begin
              state_d = S_HELD;
              timer_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (!deb_q) begin
            state_d = S_LATCHED;
          end
        end
        S_LATCHED: begin
          if (iOffSignal[g]) state_d = S_IDLE;
        end
        S_HELD: begin
          if (!deb_q) begin
            state_d = S_IDLE;
          end else if (REPEAT_EN[g]) begin
            if (timer_q == limit) begin
              state_d = S_PENDING;
              first_d = 1'b0;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign oSignal[g]    = (state_q == S_PENDING) || (state_q == S_LATCHED);
    assign oDebounced[g] = deb_q;

    if (g == LED_CHANNEL) begin : g_led
      assign oLEDs = state_q;
    end
  end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank with short debounce/repeat timings;
// expected values are hand-derived from the edge-by-edge latency rules.
module tb_button_bank;

  logic       clk = 1'b0;
  logic       iReset;
  logic [3:0] iButton;
  logic [3:0] iOffSignal;
  logic [3:0] oSignal;
  logic [3:0] oDebounced;
  logic [4:0] oLEDs;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [4:0] L_IDLE    = 5'b00001;
  localparam logic [4:0] L_PENDING = 5'b00010;
  localparam logic [4:0] L_LATCHED = 5'b00100;
  localparam logic [4:0] L_HELD    = 5'b10000;

  button_bank #(
    .N_BUTTONS        (4),
    .DEBOUNCE_CYCLES  (4),
    .REPEAT_DELAY     (20),
    .REPEAT_RATE      (8),
    .REPEAT_EN        (4'b0011),
    .BUTTON_ACTIVE_LOW(1'b0),
    .LED_CHANNEL      (0)
  ) dut (
    .clk       (clk),
    .iReset    (iReset),
    .iButton   (iButton),
    .iOffSignal(iOffSignal),
    .oSignal   (oSignal),
    .oDebounced(oDebounced),
    .oLEDs     (oLEDs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    iReset     = 1'b1;
    iButton    = '0;
    iOffSignal = '0;
    tick();
    tick();
    iReset = 1'b0;
  endtask

  // Ticks until oSignal[ch] is high; returns the tick count (limit on timeout).
  task automatic wait_rise(input int unsigned ch, input int unsigned limit, output int unsigned n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (oSignal[ch]) break;
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned bad;

    iReset     = 1'b1;
    iButton    = '0;
    iOffSignal = '0;
    do_reset();
    check("rst_sig", oSignal, 0);
    check("rst_deb", oDebounced, 0);
    check("rst_led", oLEDs, L_IDLE);

    // 1: ch0 held from edge 0, no ack
    iButton[0] = 1'b1;
    bad = 0;
    for (int k = 0; k <= 100; k++) begin
      tick();
      if (k == 4) begin
        check("t1_deb_e4", oDebounced[0], 0);
        check("t1_sig_e4", oSignal[0], 0);
      end
      if (k == 5) begin
        check("t1_deb_e5", oDebounced[0], 1);
        check("t1_sig_e5", oSignal[0], 0);
        check("t1_led_e5", oLEDs, L_IDLE);
      end
      if (k == 6) begin
        check("t1_sig_e6", oSignal[0], 1);
        check("t1_led_e6", oLEDs, L_PENDING);
      end
      if (k >= 6 && !oSignal[0]) bad++;
    end
    check("t1_hold_lows", bad, 0);

    // 2: 3-cycle glitch on ch2 is rejected
    do_reset();
    iButton[2] = 1'b1;
    tick(); tick(); tick();
    iButton[2] = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (oDebounced[2] || oSignal[2] || oLEDs != L_IDLE) bad++;
    end
    check("t2_glitch", bad, 0);

    // 3: ch0+ch1 press/release -> LATCHED, ack ch1 only, then ch0
    do_reset();
    iButton[1:0] = 2'b11;
    for (int k = 0; k < 10; k++) tick();
    iButton[1:0] = 2'b00;
    for (int k = 10; k <= 15; k++) tick();
    check("t3_deb_e15", oDebounced[1], 0);
    check("t3_led_e15", oLEDs, L_PENDING);
    tick();
    check("t3_led_e16", oLEDs, L_LATCHED);
    check("t3_sig1_e16", oSignal[1], 1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!oSignal[1] || !oSignal[0]) bad++;
    end
    check("t3_latched_hold", bad, 0);
    iOffSignal[1] = 1'b1;
    tick();
    iOffSignal[1] = 1'b0;
    check("t3_sig1_ack", oSignal[1], 0);
    check("t3_sig0_indep", oSignal[0], 1);
    check("t3_led_indep", oLEDs, L_LATCHED);
    iOffSignal[0] = 1'b1;
    tick();
    check("t3_led_ack0", oLEDs, L_IDLE);
    tick();
    iOffSignal[0] = 1'b0;
    check("t3_idle_ignores_ack", oLEDs, L_IDLE);

    // 4: auto-repeat on ch0, 20 cycles to first repeat then 8
    do_reset();
    iButton[0] = 1'b1;
    wait_rise(0, 40, n);
    check("t4_first_req", n, 7);
    iOffSignal[0] = 1'b1;
    tick();
    iOffSignal[0] = 1'b0;
    check("t4_led_held", oLEDs, L_HELD);
    check("t4_sig_acked", oSignal[0], 0);
    wait_rise(0, 50, n);
    check("t4_delay", n, 20);
    for (int r = 0; r < 3; r++) begin
      iOffSignal[0] = 1'b1;
      tick();
      iOffSignal[0] = 1'b0;
      wait_rise(0, 50, n);
      check("t4_rate", n, 8);
    end
    iOffSignal[0] = 1'b1;
    tick();
    iOffSignal[0] = 1'b0;
    iButton[0]    = 1'b0;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (oSignal[0]) bad++;
    end
    check("t4_release_norise", bad, 0);
    check("t4_release_led", oLEDs, L_IDLE);

    // 5: ch3 has no repeat; held after ack never re-fires
    do_reset();
    iButton[3] = 1'b1;
    wait_rise(3, 40, n);
    check("t5_req", n, 7);
    iOffSignal[3] = 1'b1;
    tick();
    iOffSignal[3] = 1'b0;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (oSignal[3]) bad++;
    end
    check("t5_no_refire", bad, 0);
    iButton[3] = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("t5_released_deb", oDebounced[3], 0);
    check("t5_released_sig", oSignal[3], 0);
    iButton[3] = 1'b1;
    wait_rise(3, 40, n);
    check("t5_repress", n, 7);

    // 6: one-cycle reset while ch0 HELD, key still down
    do_reset();
    iButton[0] = 1'b1;
    wait_rise(0, 40, n);
    iOffSignal[0] = 1'b1;
    tick();
    iOffSignal[0] = 1'b0;
    tick(); tick(); tick();
    check("t6_pre_led", oLEDs, L_HELD);
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    check("t6_rst_sig", oSignal, 0);
    check("t6_rst_deb", oDebounced, 0);
    check("t6_rst_led", oLEDs, L_IDLE);
    // First non-reset edge acts as edge 0, so the request follows its edge 6.
    wait_rise(0, 40, n);
    check("t6_rereq", n, 7);
    check("t6_led", oLEDs, L_PENDING);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
